// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Oversampling UART receiver with configurable frame format (DATA_W data
//   bits, optional even/odd parity, STOP_BITS stop bits). Each completed
//   frame is tagged with parity/framing error flags and pushed into a small
//   first-word-fall-through FIFO drained through a valid/ready handshake.
//
// Ports
//   sysclk         clock
//   reset_n        synchronous active-low reset
//   rx_i           asynchronous serial line, idle high
//   parity_mode_i  00/11 none, 01 even, 10 odd (latched at start edge)
//   rx_ready_i     consumer accepts head entry
//   rx_valid_o     FIFO non-empty
//   rx_data_o      head entry data, LSB = first received bit
//   rx_perr_o      head entry parity error
//   rx_ferr_o      head entry framing error
//   break_o        one-cycle pulse in the push cycle of a break frame
//   overrun_o      one-cycle pulse when a frame is dropped on a full FIFO
//   fifo_count_o   entries held, 0..DEPTH
module uart_rx_fifo #(
  parameter int DATA_W    = 8,
  parameter int OVS       = 16,
  parameter int PSCALER   = 1,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 4
) (
  input  logic                     sysclk,
  input  logic                     reset_n,
  input  logic                     rx_i,
  input  logic [1:0]               parity_mode_i,
  input  logic                     rx_ready_i,
  output logic                     rx_valid_o,
  output logic [DATA_W-1:0]        rx_data_o,
  output logic                     rx_perr_o,
  output logic                     rx_ferr_o,
  output logic                     break_o,
  output logic                     overrun_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);

  localparam int TW = $clog2(OVS);
  localparam int PW = (PSCALER > 1) ? $clog2(PSCALER) : 1;
  localparam int BW = $clog2(DATA_W);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_W + 2;

  localparam logic [TW-1:0] T_S0   = TW'(OVS/2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVS/2);
  localparam logic [TW-1:0] T_DEC  = TW'(OVS/2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PSCALER - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  // synchroniser + edge register
  logic sync1_q, rxs_q, rxs_prev_q;

  // receiver state
  state_t            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [1:0]        samp_q, samp_d;
  logic [BW-1:0]     bit_idx_q, bit_idx_d;
  logic              stop_idx_q, stop_idx_d;
  logic [1:0]        pmode_q, pmode_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              par_bit_q, par_bit_d;
  logic              stop0_q, stop0_d;
  logic              push_q, push_d;
  logic              brk_q, brk_d;

  // FIFO
  logic [EW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic fall, tick, dec, vote, par_en, last_stop;
  logic full, pop, push_ok;
  logic [EW-1:0] head;

  assign fall      = rxs_prev_q & ~rxs_q;
  assign tick      = (presc_q == P_LAST);
  assign dec       = tick && (tick_cnt_q == T_DEC);
  // majority of the two stored samples and the live one at the decision tick
  assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);
  assign par_en    = (pmode_q == 2'b01) || (pmode_q == 2'b10);
  assign last_stop = (STOP_BITS == 1) || stop_idx_q;

  // Receiver next state. The tick counter free-runs across bit boundaries
  // while a frame is active; the state tells which bit the next decision
  // belongs to, so state changes happen on decision ticks. That lets the
  // last stop bit return to IDLE without waiting out its second half.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    tick_cnt_d = tick_cnt_q;
    samp_d     = samp_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    pmode_d    = pmode_q;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    par_bit_d  = par_bit_q;
    stop0_d    = stop0_q;
    push_d     = 1'b0;
    brk_d      = 1'b0;

    if (state_q != S_IDLE) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        tick_cnt_d = (tick_cnt_q == T_LAST) ? '0 : tick_cnt_q + TW'(1);
        if (tick_cnt_q == T_S0) samp_d[0] = rxs_q;
        if (tick_cnt_q == T_S1) samp_d[1] = rxs_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        presc_d    = '0;
        tick_cnt_d = '0;
        if (fall) begin
          state_d    = S_START;
          pmode_d    = parity_mode_i;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          par_bit_d  = 1'b0;
          stop0_d    = 1'b1;
        end
      end
      S_START: begin
        if (dec) state_d = vote ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (dec) begin
          data_d    = {vote, data_q[DATA_W-1:1]};
          bit_idx_d = bit_idx_q + BW'(1);
          if (bit_idx_q == B_LAST) state_d = par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (dec) begin
          par_bit_d = vote;
          perr_d    = ((^data_q) ^ vote) != (pmode_q == 2'b10);
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (dec) begin
          if (!vote) ferr_d = 1'b1;
          if (!stop_idx_q) stop0_d = vote;
          if (last_stop) begin
            push_d  = 1'b1;
            // break: all data zero, parity bit zero, first stop zero
            brk_d   = (data_q == '0) && !par_bit_q &&
                      !(stop_idx_q ? stop0_q : vote);
            state_d = S_IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO control: a push at full is accepted only when a pop frees a slot
  // in the same cycle.
  assign full    = (count_q == C_FULL);
  assign pop     = rx_valid_o && rx_ready_i;
  assign push_ok = push_q && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      presc_q    <= '0;
      tick_cnt_q <= '0;
      samp_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      pmode_q    <= '0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      par_bit_q  <= 1'b0;
      stop0_q    <= 1'b0;
      push_q     <= 1'b0;
      brk_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sync1_q    <= rx_i;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
      state_q    <= state_d;
      presc_q    <= presc_d;
      tick_cnt_q <= tick_cnt_d;
      samp_q     <= samp_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      pmode_q    <= pmode_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      par_bit_q  <= par_bit_d;
      stop0_q    <= stop0_d;
      push_q     <= push_d;
      brk_q      <= brk_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      // frame fields stay stable through the push cycle (FSM is in IDLE)
      if (push_ok) mem_q[wr_ptr_q] <= {ferr_q, perr_q, data_q};
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign rx_valid_o   = (count_q != '0);
  assign rx_data_o    = head[DATA_W-1:0];
  assign rx_perr_o    = head[DATA_W];
  assign rx_ferr_o    = head[DATA_W+1];
  assign break_o      = brk_q;
  assign overrun_o    = push_q && full && !pop;
  assign fifo_count_o = count_q;

endmodule
